// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for a programmable integer clock divider.
// Holds the active divide ratio, runs the period counter, and applies ratio
// changes only at a period boundary. Produces a registered per-period tick
// (clock enable) and a registered divided waveform.
// Optional build macro CLK_DIV_CTRL_CNT_EN adds a 16-bit period_cnt output
// that counts ticks.
module clk_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             div_req,
    input  logic [WIDTH-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             div_busy,
    output logic             tick,
    output logic             div_out,
`ifdef CLK_DIV_CTRL_CNT_EN
    output logic [15:0]      period_cnt,
`endif
    output logic [WIDTH-1:0] cur_div
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO_C  = {{(WIDTH-2){1'b0}}, 2'b10};
    localparam logic [WIDTH-1:0] DEF_C  = WIDTH'(DEFAULT_DIV);

    // Number of high cycles in a period: ceil(n/2), computed one bit wider
    // so the largest ratio does not overflow.
    function automatic logic [WIDTH:0] high_len(input logic [WIDTH-1:0] n);
        return ({1'b0, n} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] cur_div_r, cur_div_s;
    logic [WIDTH-1:0] pend_div_r, pend_div_s;
    logic             ack_r, ack_s;
    logic             err_r, err_s;
    logic             busy_r, busy_s;
    logic             tick_r, tick_s;
    logic             div_out_r, div_out_s;
    logic             wrap_s;
    logic             req_ok_s;
    logic             req_bad_s;

    // Next-state, counter and ratio-update logic; outputs are computed from
    // the next values so that the registered outputs line up with cnt_r.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        cur_div_s  = cur_div_r;
        pend_div_s = pend_div_r;
        ack_s      = 1'b0;
        err_s      = 1'b0;
        busy_s     = busy_r;
        wrap_s     = (cnt_r == (cur_div_r - ONE_C));
        req_ok_s   = div_req & ~busy_r;
        req_bad_s  = (div_val < TWO_C);

        // Too-small ratios are rejected in any non-busy state.
        if (req_ok_s && req_bad_s) begin
            ack_s = 1'b1;
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end

        case (state_r)
            ST_STOP: begin
                cnt_s = ZERO_C;
                if (req_ok_s && !req_bad_s) begin
                    cur_div_s = div_val;
                    ack_s     = 1'b1;
                end else begin
                    cur_div_s = cur_div_r;
                end
                if (enable) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_RUN: begin
                cnt_s = wrap_s ? ZERO_C : (cnt_r + ONE_C);
                if (req_ok_s && !req_bad_s) begin
                    // A request on the wrap cycle still waits a full period.
                    pend_div_s = div_val;
                    busy_s     = 1'b1;
                    state_s    = ST_PEND;
                end else if (wrap_s && !enable) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PEND: begin
                cnt_s = wrap_s ? ZERO_C : (cnt_r + ONE_C);
                if (wrap_s) begin
                    cur_div_s = pend_div_r;
                    ack_s     = 1'b1;
                    busy_s    = 1'b0;
                    state_s   = enable ? ST_RUN : ST_STOP;
                end else begin
                    state_s = ST_PEND;
                end
            end
            default: begin
                state_s = ST_STOP;
                cnt_s   = ZERO_C;
                busy_s  = 1'b0;
            end
        endcase

        tick_s    = (state_s != ST_STOP) && (cnt_s == ZERO_C);
        div_out_s = (state_s != ST_STOP) && ({1'b0, cnt_s} < high_len(cur_div_s));
    end

    // State, counter, ratio and registered output flops.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_STOP;
            cnt_r      <= ZERO_C;
            cur_div_r  <= DEF_C;
            pend_div_r <= ZERO_C;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            tick_r     <= 1'b0;
            div_out_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            cur_div_r  <= cur_div_s;
            pend_div_r <= pend_div_s;
            ack_r      <= ack_s;
            err_r      <= err_s;
            busy_r     <= busy_s;
            tick_r     <= tick_s;
            div_out_r  <= div_out_s;
        end
    end

`ifdef CLK_DIV_CTRL_CNT_EN
    logic [15:0] period_cnt_r;

    // Tick counter: advances together with each registered tick, wraps freely.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            period_cnt_r <= 16'h0000;
        end else if (tick_s) begin
            period_cnt_r <= period_cnt_r + 16'h0001;
        end else begin
            period_cnt_r <= period_cnt_r;
        end
    end

    assign period_cnt = period_cnt_r;
`endif

    assign div_ack  = ack_r;
    assign div_err  = err_r;
    assign div_busy = busy_r;
    assign tick     = tick_r;
    assign div_out  = div_out_r;
    assign cur_div  = cur_div_r;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed testbench for clk_div_ctrl: hand-computed expectations per scenario.
module tb_clk_div_ctrl;

    localparam int WIDTH = 8;

    logic             clk_in;
    logic             rst;
    logic             enable;
    logic             div_req;
    logic [WIDTH-1:0] div_val;
    logic             div_ack;
    logic             div_err;
    logic             div_busy;
    logic             tick;
    logic             div_out;
    logic [WIDTH-1:0] cur_div;
`ifdef CLK_DIV_CTRL_CNT_EN
    logic [15:0]      period_cnt;
`endif

    int n_cmp;
    int n_bad;

    clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(3)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .enable   (enable),
        .div_req  (div_req),
        .div_val  (div_val),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .div_busy (div_busy),
        .tick     (tick),
        .div_out  (div_out),
`ifdef CLK_DIV_CTRL_CNT_EN
        .period_cnt (period_cnt),
`endif
        .cur_div  (cur_div)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance one clock; outputs are read 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        #100;
        n_cmp++; if (cur_div !== 8'd3) begin n_bad++; $display("FAIL reset_cur_div: got %0d expected 3", cur_div); end
        n_cmp++; if ({tick, div_out, div_ack, div_err, div_busy} !== 5'b00000) begin
            n_bad++; $display("FAIL reset_outputs: got %b expected 00000", {tick, div_out, div_ack, div_err, div_busy}); end
`ifdef CLK_DIV_CTRL_CNT_EN
        n_cmp++; if (period_cnt !== 16'h0000) begin n_bad++; $display("FAIL reset_period_cnt: got %0d expected 0", period_cnt); end
`endif
        @(posedge clk_in); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if ({tick, div_out} !== 2'b00) begin
                n_bad++; $display("FAIL idle_after_reset: got %b expected 00", {tick, div_out}); end
        end
    endtask

    task automatic test_default_run();
        int ticks;
        ticks = 0;
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tick === 1'b1) ticks++;
            n_cmp++; if (tick !== ((i % 3) == 0)) begin
                n_bad++; $display("FAIL run3_tick i=%0d: got %b expected %b", i, tick, (i % 3) == 0); end
            n_cmp++; if (div_out !== ((i % 3) < 2)) begin
                n_bad++; $display("FAIL run3_div_out i=%0d: got %b expected %b", i, div_out, (i % 3) < 2); end
        end
        n_cmp++; if (ticks != 10) begin n_bad++; $display("FAIL run3_tick_count: got %0d expected 10", ticks); end
        n_cmp++; if (cur_div !== 8'd3) begin n_bad++; $display("FAIL run3_cur_div: got %0d expected 3", cur_div); end
    endtask

    // Enters at cnt=2 of ratio 3; leaves at cnt=3 of ratio 4.
    task automatic test_mid_change();
        step();  // cnt=0
        step();  // cnt=1
        div_req = 1'b1; div_val = 8'd4;
        step();  // cnt=2, request accepted
        div_req = 1'b0;
        n_cmp++; if (div_busy !== 1'b1) begin n_bad++; $display("FAIL chg_busy: got %b expected 1", div_busy); end
        n_cmp++; if (div_ack !== 1'b0) begin n_bad++; $display("FAIL chg_early_ack: got %b expected 0", div_ack); end
        n_cmp++; if (cur_div !== 8'd3) begin n_bad++; $display("FAIL chg_early_cur_div: got %0d expected 3", cur_div); end
        div_req = 1'b1; div_val = 8'd7;  // arrives while busy: must be ignored
        step();  // wrap: new ratio applied
        div_req = 1'b0;
        n_cmp++; if (cur_div !== 8'd4) begin n_bad++; $display("FAIL chg_cur_div: got %0d expected 4", cur_div); end
        n_cmp++; if ({div_ack, div_err, div_busy} !== 3'b100) begin
            n_bad++; $display("FAIL chg_ack: got %b expected 100", {div_ack, div_err, div_busy}); end
        n_cmp++; if ({tick, div_out} !== 2'b11) begin n_bad++; $display("FAIL chg_first_tick: got %b expected 11", {tick, div_out}); end
        for (int i = 1; i < 8; i++) begin
            step();
            n_cmp++; if ({tick, div_out} !== {(i % 4) == 0, (i % 4) < 2}) begin
                n_bad++; $display("FAIL run4_wave i=%0d: got %b expected %b", i, {tick, div_out}, {(i % 4) == 0, (i % 4) < 2}); end
            n_cmp++; if ({div_ack, cur_div} !== {1'b0, 8'd4}) begin
                n_bad++; $display("FAIL busy_req_ignored i=%0d: got ack=%b div=%0d expected ack=0 div=4", i, div_ack, cur_div); end
        end
    endtask

    // Enters at cnt=3 of ratio 4; leaves at cnt=0 of ratio 4.
    task automatic test_invalid();
        div_req = 1'b1; div_val = 8'd1;
        step();  // cnt=0
        div_req = 1'b0;
        n_cmp++; if ({div_ack, div_err, tick} !== 3'b111) begin
            n_bad++; $display("FAIL inv1_ack_err: got %b expected 111", {div_ack, div_err, tick}); end
        n_cmp++; if (cur_div !== 8'd4) begin n_bad++; $display("FAIL inv1_cur_div: got %0d expected 4", cur_div); end
        step();  // cnt=1
        n_cmp++; if ({div_ack, div_err} !== 2'b00) begin n_bad++; $display("FAIL inv_pulse_len: got %b expected 00", {div_ack, div_err}); end
        div_req = 1'b1; div_val = 8'd0;
        step();  // cnt=2
        div_req = 1'b0;
        n_cmp++; if ({div_ack, div_err, div_busy, tick, div_out} !== 5'b11000) begin
            n_bad++; $display("FAIL inv0_ack_err: got %b expected 11000", {div_ack, div_err, div_busy, tick, div_out}); end
        step();  // cnt=3
        step();  // cnt=0
        n_cmp++; if ({tick, cur_div} !== {1'b1, 8'd4}) begin
            n_bad++; $display("FAIL inv_ticks_continue: got tick=%b div=%0d expected tick=1 div=4", tick, cur_div); end
    endtask

    // Switch to ratio 5, stop at the boundary, restart from STOP with ratio 3.
    task automatic test_stop_boundary();
        div_req = 1'b1; div_val = 8'd5;
        step();  // cnt=1, PEND
        div_req = 1'b0;
        step();  // cnt=2
        step();  // cnt=3
        step();  // wrap -> ratio 5, cnt=0
        n_cmp++; if ({cur_div, div_ack, tick} !== {8'd5, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL r5_apply: got div=%0d ack=%b tick=%b expected 5 1 1", cur_div, div_ack, tick); end
        step();  // cnt=1
        enable = 1'b0;
        for (int i = 2; i < 5; i++) begin
            step();
            n_cmp++; if ({tick, div_out} !== {1'b0, i < 3}) begin
                n_bad++; $display("FAIL stop_drain cnt=%0d: got %b expected %b", i, {tick, div_out}, {1'b0, i < 3}); end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if ({tick, div_out} !== 2'b00) begin
                n_bad++; $display("FAIL stopped i=%0d: got %b expected 00", i, {tick, div_out}); end
        end
        enable = 1'b1; div_req = 1'b1; div_val = 8'd3;
        step();  // ratio applied and RUN entered on the same edge
        div_req = 1'b0;
        n_cmp++; if ({tick, div_out, div_ack, div_busy, cur_div} !== {4'b1110, 8'd3}) begin
            n_bad++; $display("FAIL restart_apply: got tick=%b out=%b ack=%b busy=%b div=%0d expected 1 1 1 0 3",
                              tick, div_out, div_ack, div_busy, cur_div); end
        step(); step();  // cnt=1, cnt=2
        step();
        n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL restart_period3: got %b expected 1", tick); end
    endtask

    // Enters at cnt=0 of ratio 3.
    task automatic test_reset_pend();
        div_req = 1'b1; div_val = 8'd6;
        step();  // cnt=1, PEND
        div_req = 1'b0;
        n_cmp++; if (div_busy !== 1'b1) begin n_bad++; $display("FAIL rp_busy: got %b expected 1", div_busy); end
        #2;
        rst = 1'b0;
        enable = 1'b0;
        #1;
        n_cmp++; if ({div_busy, div_ack, tick, div_out, cur_div} !== {4'b0000, 8'd3}) begin
            n_bad++; $display("FAIL rp_async: got busy=%b ack=%b tick=%b out=%b div=%0d expected 0 0 0 0 3",
                              div_busy, div_ack, tick, div_out, cur_div); end
`ifdef CLK_DIV_CTRL_CNT_EN
        n_cmp++; if (period_cnt !== 16'h0000) begin n_bad++; $display("FAIL rp_period_cnt: got %0d expected 0", period_cnt); end
`endif
        step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++; if ({div_ack, div_busy, tick, cur_div} !== {3'b000, 8'd3}) begin
                n_bad++; $display("FAIL rp_after i=%0d: got ack=%b busy=%b tick=%b div=%0d expected 0 0 0 3",
                                  i, div_ack, div_busy, tick, cur_div); end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        enable  = 1'b0;
        div_req = 1'b0;
        div_val = 8'd0;
        test_reset();
        test_default_run();
        test_mid_change();
        test_invalid();
        test_stop_boundary();
        test_reset_pend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
